frame_update_scheduler: RTL and testbench

- Sequences per-frame game-state updates (ship, asteroids, bullets, score) into the vertical blanking interval.
- Watches the pixel_x/pixel_y counters from the VGA timing generator and opens an update window at the first blank line.
- Grants exclusive update access to one requester at a time, in fixed priority order, at most once per frame.
- Revokes access and flags an overrun if the window closes before all pending requesters finish.

---
 rtl/frame_update_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_frame_update_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler
//
// Sequences per-frame game-state updates (ship, asteroids, bullets, score)
// into the vertical blanking interval. The update window opens on the first
// blank line reported by the VGA timing generator. Each pending requester
// gets exclusive access once per frame, lowest index first. If the last line
// of the frame arrives before every pending requester has finished, the
// current grant is revoked and a sticky overrun flag is raised.
//
// Optional feature (macro UPDATE_WDOG_EN):
//   A per-grant watchdog revokes a grant held for MAX_GRANT_CYCLES clocks,
//   marks that requester served, sets sticky wdog_err and moves on to the
//   next requester. Without the macro wdog_err is tied low and a grant is
//   held until done, request drop or deadline.
//
// Ports:
//   clk          system clock, same domain as the timing generator
//   on_sw        asynchronous active-low reset; block runs while high
//   pixel_x      horizontal counter from the timing generator
//   pixel_y      vertical counter from the timing generator
//   req          per-requester update request (level)
//   done         per-requester completion, only the granted bit is observed
//   grant        registered one-hot (or zero) grant
//   busy         high while the scheduler is outside IDLE
//   frame_done   one-clock pulse when every pending request was served in time
//   overrun      sticky missed-deadline flag, cleared only by reset
//   frame_count  number of windows opened, wraps at 16 bits
//   wdog_err     sticky per-grant watchdog error
//
// States:
//   IDLE  | waiting for the window to open
//   SCAN  | choosing the next unserved requester (grant is low here)
//   GRANT | one requester owns the update path until it finishes

module frame_update_scheduler #(
  parameter int N_REQ            = 4,
  parameter int WIN_START_LINE   = 480,
  parameter int WIN_END_LINE     = 524,
  parameter int MAX_GRANT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             on_sw,
  input  logic [10:0]      pixel_x,
  input  logic [10:0]      pixel_y,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun,
  output logic [15:0]      frame_count,
  output logic             wdog_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0] START_Y = 11'(WIN_START_LINE);
  localparam logic [10:0] END_Y   = 11'(WIN_END_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state;
  logic [N_REQ-1:0] served;
  logic [IDX_W-1:0] cur_idx;
  logic             start_d;

  logic             start_cond;
  logic             start_pulse;
  logic             deadline;
  logic [N_REQ-1:0] pending;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             cur_release;
  logic             wdog_hit;

  // The counters advance every other clock, so start_cond is high for two
  // clocks; the edge detect turns it into a single pulse per frame.
  assign start_cond  = (pixel_y == START_Y) && (pixel_x == 11'd0);
  assign start_pulse = start_cond & ~start_d;
  assign deadline    = (pixel_y == END_Y);

  assign pending = req & ~served;

  // Walk from the top index down so the lowest pending index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(i);
      end
    end
  end

  assign pick_onehot = N_REQ'(1) << pick_idx;

  // A requester that drops its request mid-grant is treated as finished.
  assign cur_release = done[cur_idx] | ~req[cur_idx];

  assign busy = (state != IDLE);

`ifdef UPDATE_WDOG_EN
  localparam int WDOG_W = ($clog2(MAX_GRANT_CYCLES + 1) > 13) ?
                          $clog2(MAX_GRANT_CYCLES + 1) : 13;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_fire;

  // Every GRANT entry comes from SCAN, so clearing in SCAN restarts the count
  // for each new grant. The count holds MAX-1 on the last allowed GRANT clock.
  assign wdog_hit  = (wdog_cnt == WDOG_W'(MAX_GRANT_CYCLES - 1));
  assign wdog_fire = (state == GRANT) && wdog_hit && !cur_release &&
                     !deadline && !start_pulse;

  always_ff @(posedge clk or negedge on_sw) begin
    if (!on_sw) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == GRANT) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end else begin
        wdog_cnt <= '0;
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog_cfg;

  assign wdog_hit        = 1'b0;
  assign wdog_err        = 1'b0;
  assign unused_wdog_cfg = ^(32'(MAX_GRANT_CYCLES));
`endif

  always_ff @(posedge clk or negedge on_sw) begin
    if (!on_sw) begin
      state       <= IDLE;
      grant       <= '0;
      served      <= '0;
      cur_idx     <= '0;
      start_d     <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      start_d    <= start_cond;
      frame_done <= 1'b0;

      if (start_pulse) begin
        // A new window while still busy means the previous one never closed
        // (line parameters overlap); abort it and start the new frame.
        if (state != IDLE) begin
          overrun <= 1'b1;
        end
        grant       <= '0;
        served      <= '0;
        frame_count <= frame_count + 16'd1;
        state       <= SCAN;
      end else begin
        case (state)
          IDLE: begin
            grant <= '0;
          end

          SCAN: begin
            if (deadline) begin
              overrun <= 1'b1;
              grant   <= '0;
              state   <= IDLE;
            end else if (pick_valid) begin
              grant   <= pick_onehot;
              cur_idx <= pick_idx;
              state   <= GRANT;
            end else begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end

          GRANT: begin
            // Deadline wins over a simultaneous done or watchdog expiry.
            if (deadline) begin
              overrun <= 1'b1;
              grant   <= '0;
              state   <= IDLE;
            end else if (cur_release || wdog_hit) begin
              served[cur_idx] <= 1'b1;
              grant           <= '0;
              state           <= SCAN;
            end
          end

          default: begin
            grant <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_update_scheduler.sv
`timescale 1ns/1ps
module tb_frame_update_scheduler;

  localparam int N_REQ      = 4;
  localparam int H_PIX      = 16;
  localparam int RESP_DELAY = 10;

  localparam int EV_GRANT = 0;
  localparam int EV_FD    = 1;
  localparam int EV_OVR   = 2;

  typedef struct packed {
    int kind;
    int data;
    int aux;
  } ev_t;

  logic             clk;
  logic             on_sw;
  logic [10:0]      px;
  logic [10:0]      py;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             frame_done;
  logic             overrun;
  logic [15:0]      frame_count;
  logic             wdog_err;

  logic [N_REQ-1:0] resp_en;
  logic             gen_run;
  logic             phase;

  ev_t exp_q[$];
  int  checks;
  int  failures;
  int  cyc;
  int  start_cyc;
  int  last_evt_cyc;
  int  exp_fc;
  int  rcnt [N_REQ];
  logic [N_REQ-1:0] prev_grant;
  logic             prev_ovr;

  frame_update_scheduler #(
    .N_REQ            (N_REQ),
    .WIN_START_LINE   (480),
    .WIN_END_LINE     (524),
    .MAX_GRANT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .on_sw       (on_sw),
    .pixel_x     (px),
    .pixel_y     (py),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .frame_count (frame_count),
    .wdog_err    (wdog_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Compressed timing generator: short lines, and only lines 478..524 are
  // visited so each frame takes about 1500 clocks. Each position is held for
  // two clocks like the real generator.
  initial begin
    px = 11'd0;
    py = 11'd478;
    phase = 1'b0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (gen_run) begin
        phase = ~phase;
        if (!phase) begin
          if (px == 11'(H_PIX - 1)) begin
            px = 11'd0;
            py = (py == 11'd524) ? 11'd478 : py + 11'd1;
          end else begin
            px = px + 11'd1;
          end
          if (py == 11'd480 && px == 11'd0) start_cyc = cyc;
        end
      end
    end
  end

  // Requester model: pulses done RESP_DELAY clocks after its grant rises.
  initial begin
    done = '0;
    for (int i = 0; i < N_REQ; i++) rcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i] && resp_en[i]) begin
          rcnt[i]++;
          done[i] = (rcnt[i] == RESP_DELAY);
        end else begin
          rcnt[i] = 0;
          done[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req_v);
    end
  endtask

  task automatic push(input int kind, input int data, input int aux);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  // aux = clocks since the previous output event or window start,
  // whichever is later; an expected aux of -1 means "not checked".
  task automatic got_event(input int kind, input int data);
    ev_t e;
    int ref_c;
    int aux;
    ref_c = (start_cyc > last_evt_cyc) ? start_cyc : last_evt_cyc;
    aux = cyc - ref_c;
    last_evt_cyc = cyc;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=0x%0h delay=%0d expected no event",
               kind, data, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data != data || (e.aux >= 0 && e.aux != aux)) begin
        failures++;
        $display("FAIL event: got kind=%0d data=0x%0h delay=%0d expected kind=%0d data=0x%0h delay=%0d",
                 kind, data, aux, e.kind, e.data, e.aux);
      end
    end
  endtask

  initial begin
    prev_grant = '0;
    prev_ovr = 1'b0;
    last_evt_cyc = 0;
    forever begin
      @(negedge clk);
      if (grant !== prev_grant) begin
        got_event(EV_GRANT, int'(grant));
        prev_grant = grant;
      end
      if (frame_done) got_event(EV_FD, int'(frame_count));
      if (overrun && !prev_ovr) got_event(EV_OVR, 0);
      prev_ovr = overrun;
    end
  end

  task automatic wait_line(input int y);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      if (int'(py) == y) begin
        hit = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_line: timed out at line %0d waiting for line %0d", py, y);
    end
  endtask

  task automatic wait_grant(input int v);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (int'(grant) == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_grant: timed out with grant=0x%0h waiting for 0x%0h", grant, v);
    end
  endtask

  task automatic begin_frame(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] en);
    wait_line(479);
    req = r;
    resp_en = en;
    exp_fc++;
  endtask

  task automatic end_frame();
    wait_line(524);
    wait_line(478);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_fc = 0;
    on_sw = 1'b1;
    req = '0;
    resp_en = '0;
    gen_run = 1'b0;

    #1 on_sw = 1'b0;
    #1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_wdog_err", int'(wdog_err), 0);
    @(negedge clk);
    @(negedge clk);
    on_sw = 1'b1;
    gen_run = 1'b1;

    // Two requesters served in priority order with a one-clock SCAN gap.
    begin_frame(4'b0101, 4'b1111);
    push(EV_GRANT, 1, 2);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_GRANT, 4, 1);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    end_frame();
    chk("f1_overrun", int'(overrun), 0);
    chk("f1_frame_count", int'(frame_count), exp_fc);
    chk("f1_queue_drained", exp_q.size(), 0);

    // No requests: frame_done two clocks after the window opens.
    begin_frame(4'b0000, 4'b1111);
    push(EV_FD, exp_fc, 2);
    end_frame();
    chk("f2_frame_count", int'(frame_count), exp_fc);

`ifndef UPDATE_WDOG_EN
    // Requester never finishes: grant held until the deadline line.
    begin_frame(4'b0010, 4'b0000);
    push(EV_GRANT, 2, 2);
    push(EV_GRANT, 0, -1);
    push(EV_OVR, 0, 0);
    wait_line(523);
    chk("f3_grant_held", int'(grant), 2);
    chk("f3_busy", int'(busy), 1);
    end_frame();
    chk("f3_overrun", int'(overrun), 1);
    chk("f3_busy_after", int'(busy), 0);

    // Next frame grants again; overrun remains sticky.
    begin_frame(4'b0010, 4'b0010);
    push(EV_GRANT, 2, 2);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    end_frame();
    chk("f4_overrun_sticky", int'(overrun), 1);
`endif

    // Late request from index 3 joins this frame; re-request from 0 waits.
    begin_frame(4'b0001, 4'b1111);
    push(EV_GRANT, 1, 2);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_GRANT, 8, 1);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    wait_grant(1);
    repeat (3) @(negedge clk);
    req[3] = 1'b1;
    wait_grant(0);
    req[0] = 1'b0;
    wait_grant(8);
    repeat (2) @(negedge clk);
    req[0] = 1'b1;
    end_frame();

    begin_frame(4'b0001, 4'b1111);
    push(EV_GRANT, 1, 2);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    end_frame();
    chk("f6_frame_count", int'(frame_count), exp_fc);

    // Asynchronous reset in the middle of a grant.
    begin_frame(4'b0100, 4'b0000);
    push(EV_GRANT, 4, 2);
    push(EV_GRANT, 0, -1);
    wait_grant(4);
    repeat (3) @(negedge clk);
    chk("f7_busy_in_grant", int'(busy), 1);
    #2 on_sw = 1'b0;
    #1;
    chk("f7_async_grant", int'(grant), 0);
    chk("f7_async_busy", int'(busy), 0);
    chk("f7_async_frame_count", int'(frame_count), 0);
    chk("f7_async_overrun", int'(overrun), 0);
    req = '0;
    repeat (3) @(negedge clk);
    on_sw = 1'b1;
    exp_fc = 0;
    end_frame();

    begin_frame(4'b0011, 4'b1111);
    push(EV_GRANT, 1, 2);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_GRANT, 2, 1);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    end_frame();
    chk("f8_frame_count", int'(frame_count), 1);
    chk("f8_overrun", int'(overrun), 0);

`ifdef UPDATE_WDOG_EN
    // Index 0 never finishes: watchdog revokes after 64 clocks, index 1 follows.
    begin_frame(4'b0011, 4'b0010);
    push(EV_GRANT, 1, 2);
    push(EV_GRANT, 0, 64);
    push(EV_GRANT, 2, 1);
    push(EV_GRANT, 0, RESP_DELAY);
    push(EV_FD, exp_fc, 1);
    end_frame();
    chk("wdog_err_set", int'(wdog_err), 1);
    chk("wdog_overrun", int'(overrun), 0);
`else
    chk("wdog_err_tied", int'(wdog_err), 0);
`endif

    chk("final_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
